// File: rtl/input_debounce.sv
// Synchronises and debounces the board button and slide switches, producing
// clean levels plus one-cycle commit pulses for the SoC.
module input_debounce #(
  parameter int unsigned N_SW         = 16,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic            clk_i,
  input  logic            arst_i,
  input  logic            btn_i,
  input  logic [N_SW-1:0] sw_i,
  output logic            btn_o,
  output logic            btn_rise_o,
  output logic            btn_fall_o,
  output logic [N_SW-1:0] sw_o,
  output logic            sw_chg_o
);

  localparam int unsigned N_IN  = N_SW + 1;
  localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);

  // Bit 0 is the button, bits N_SW:1 are the switches.
  logic [N_IN-1:0]             raw;
  logic [N_IN-1:0]             sync1;
  logic [N_IN-1:0]             sync2;
  logic [N_IN-1:0]             q;
  logic [N_IN-1:0]             q_nxt;
  logic [N_IN-1:0]             commit;
  logic [N_IN-1:0][CNT_W-1:0]  cnt;
  logic [N_IN-1:0][CNT_W-1:0]  cnt_nxt;
  logic [DIV_W-1:0]            div_cnt;
  logic                        tick;

  assign raw  = {sw_i, btn_i};
  assign tick = (div_cnt == DIV_W'(TICK_DIV - 1));

  // Two-stage synchronisers and shared sample-tick prescaler.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync1   <= '0;
      sync2   <= '0;
      div_cnt <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  // Per-input stability counting; any match with the committed level restarts.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    commit  = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (sync2[i] == q[i]) begin
        cnt_nxt[i] = '0;
      end else if (tick) begin
        if (cnt[i] == CNT_W'(STABLE_TICKS - 1)) begin
          q_nxt[i]   = sync2[i];
          cnt_nxt[i] = '0;
          commit[i]  = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Committed levels and pulses update on the same edge.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      q          <= '0;
      cnt        <= '0;
      btn_rise_o <= 1'b0;
      btn_fall_o <= 1'b0;
      sw_chg_o   <= 1'b0;
    end else begin
      q          <= q_nxt;
      cnt        <= cnt_nxt;
      btn_rise_o <= commit[0] & q_nxt[0];
      btn_fall_o <= commit[0] & ~q_nxt[0];
      sw_chg_o   <= |commit[N_IN-1:1];
    end
  end

  assign btn_o = q[0];
  assign sw_o  = q[N_IN-1:1];

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with a short prescaler (TICK_DIV=4, STABLE_TICKS=3).
module tb_input_debounce;

  localparam int unsigned N_SW         = 16;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned STABLE_TICKS = 3;

  logic            clk = 1'b0;
  logic            arst_i;
  logic            btn_i;
  logic [N_SW-1:0] sw_i;
  logic            btn_o;
  logic            btn_rise_o;
  logic            btn_fall_o;
  logic [N_SW-1:0] sw_o;
  logic            sw_chg_o;

  input_debounce #(
    .N_SW(N_SW),
    .TICK_DIV(TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk_i(clk),
    .arst_i(arst_i),
    .btn_i(btn_i),
    .sw_i(sw_i),
    .btn_o(btn_o),
    .btn_rise_o(btn_rise_o),
    .btn_fall_o(btn_fall_o),
    .sw_o(sw_o),
    .sw_chg_o(sw_chg_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        btn;
    logic [15:0] sw;
    int          exp_rise;
    int          exp_fall;
    int          exp_chg;
  } vec_t;

  vec_t vecs[7];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_rise, n_fall, n_chg;
  int rise_at, fall_at, chg_at;
  int bad_btn, bad_sw;
  int lat, lvl_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_cmp++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d..%0d", name, val, lo, hi);
    end
  endtask

  // One clock, sampled 1 time unit after the edge; tallies pulses.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (btn_rise_o === 1'b1) begin n_rise++; rise_at = cyc; end
    if (btn_fall_o === 1'b1) begin n_fall++; fall_at = cyc; end
    if (sw_chg_o   === 1'b1) begin n_chg++;  chg_at  = cyc; end
    if (btn_o !== 1'b0) bad_btn++;
    if (sw_o  !== 16'h0) bad_sw++;
  endtask

  task automatic clr();
    n_rise = 0; n_fall = 0; n_chg = 0;
    rise_at = -1; fall_at = -1; chg_at = -1;
    bad_btn = 0; bad_sw = 0;
  endtask

  // Steps until both levels match; lat is the edge count, or -1 on timeout.
  task automatic wait_out(input logic eb, input logic [15:0] es, input int budget, output int l);
    l = -1;
    for (int k = 1; k <= budget; k++) begin
      if (l < 0) begin
        step();
        if (btn_o === eb && sw_o === es) l = k;
      end
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'hFFFF, 0, 1, 0};
    vecs[1] = '{1'b1, 16'hFFFF, 1, 0, 0};
    vecs[2] = '{1'b0, 16'h0000, 0, 1, 1};
    vecs[3] = '{1'b1, 16'hA5A5, 1, 0, 1};
    vecs[4] = '{1'b1, 16'h5A5A, 0, 0, 1};
    vecs[5] = '{1'b0, 16'h5A5A, 0, 1, 0};
    vecs[6] = '{1'b0, 16'h0000, 0, 0, 1};

    // Reset with all inputs high, then the initial state commits as a change.
    arst_i = 1'b1;
    btn_i  = 1'b1;
    sw_i   = 16'hFFFF;
    clr();
    repeat (5) step();
    check("reset_outputs", 32'({btn_o, btn_rise_o, btn_fall_o, sw_chg_o, sw_o}), 32'd0);
    check("reset_no_pulse", 32'(n_rise + n_fall + n_chg), 32'd0);
    arst_i = 1'b0;
    clr();
    wait_out(1'b1, 16'hFFFF, 20, lat);
    lvl_at = cyc;
    repeat (8) step();
    check("post_reset_latency", 32'(lat), 32'd12);
    check("post_reset_rise_cnt", 32'(n_rise), 32'd1);
    check("post_reset_chg_cnt", 32'(n_chg), 32'd1);
    check("post_reset_fall_cnt", 32'(n_fall), 32'd0);
    check("post_reset_rise_cycle", 32'(rise_at), 32'(lvl_at));
    check("post_reset_chg_cycle", 32'(chg_at), 32'(lvl_at));

    // Clean steps on button and switches, including simultaneous commits.
    for (int v = 0; v < 7; v++) begin
      btn_i = vecs[v].btn;
      sw_i  = vecs[v].sw;
      clr();
      wait_out(vecs[v].btn, vecs[v].sw, 16, lat);
      lvl_at = cyc;
      repeat (8) step();
      check_range($sformatf("vec%0d_latency", v), lat, 11, 14);
      check($sformatf("vec%0d_btn_o", v), 32'(btn_o), 32'(vecs[v].btn));
      check($sformatf("vec%0d_sw_o", v), 32'(sw_o), 32'(vecs[v].sw));
      check($sformatf("vec%0d_rise_cnt", v), 32'(n_rise), 32'(vecs[v].exp_rise));
      check($sformatf("vec%0d_fall_cnt", v), 32'(n_fall), 32'(vecs[v].exp_fall));
      check($sformatf("vec%0d_chg_cnt", v), 32'(n_chg), 32'(vecs[v].exp_chg));
      if (vecs[v].exp_rise != 0) check($sformatf("vec%0d_rise_cycle", v), 32'(rise_at), 32'(lvl_at));
      if (vecs[v].exp_fall != 0) check($sformatf("vec%0d_fall_cycle", v), 32'(fall_at), 32'(lvl_at));
      if (vecs[v].exp_chg  != 0) check($sformatf("vec%0d_chg_cycle", v), 32'(chg_at), 32'(lvl_at));
    end

    // Bouncing button: 3-cycle runs never accumulate enough ticks.
    clr();
    for (int k = 0; k < 40; k++) begin
      btn_i = ((k / 3) % 2 == 0);
      step();
    end
    check("bounce_btn_stable", 32'(bad_btn), 32'd0);
    check("bounce_no_rise", 32'(n_rise), 32'd0);
    btn_i = 1'b1;
    wait_out(1'b1, 16'h0000, 16, lat);
    repeat (8) step();
    check_range("bounce_settle_latency", lat, 11, 14);
    check("bounce_rise_cnt", 32'(n_rise), 32'd1);
    check("bounce_fall_cnt", 32'(n_fall), 32'd0);
    btn_i = 1'b0;
    clr();
    wait_out(1'b0, 16'h0000, 16, lat);
    repeat (8) step();
    check_range("bounce_release_latency", lat, 11, 14);

    // Glitches on sw_i[5] at every prescaler phase.
    clr();
    for (int ph = 0; ph < 4; ph++) begin
      repeat (ph + 1) step();
      sw_i = 16'h0020;
      step();
      sw_i = 16'h0000;
      repeat (7) step();
      sw_i = 16'h0020;
      repeat (6) step();
      sw_i = 16'h0000;
      repeat (10) step();
    end
    check("glitch_sw_stable", 32'(bad_sw), 32'd0);
    check("glitch_no_chg", 32'(n_chg), 32'd0);

    // Reset in the middle of a press discards progress.
    sw_i = 16'h00FF;
    clr();
    wait_out(1'b0, 16'h00FF, 16, lat);
    repeat (8) step();
    check_range("pre_reset_sw_latency", lat, 11, 14);
    btn_i = 1'b1;
    repeat (8) step();
    check("midpress_btn_still_low", 32'(btn_o), 32'd0);
    #2;
    arst_i = 1'b1;
    #1;
    check("async_reset_clears", 32'({btn_o, btn_rise_o, btn_fall_o, sw_chg_o, sw_o}), 32'd0);
    clr();
    repeat (3) step();
    check("reset_hold_outputs", 32'({btn_o, btn_rise_o, btn_fall_o, sw_chg_o, sw_o}), 32'd0);
    check("reset_hold_no_pulse", 32'(n_rise + n_fall + n_chg), 32'd0);
    arst_i = 1'b0;
    clr();
    wait_out(1'b1, 16'h00FF, 20, lat);
    lvl_at = cyc;
    repeat (8) step();
    check("restart_latency", 32'(lat), 32'd12);
    check("restart_rise_cnt", 32'(n_rise), 32'd1);
    check("restart_chg_cnt", 32'(n_chg), 32'd1);
    check("restart_rise_cycle", 32'(rise_at), 32'(lvl_at));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
